// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared types and helpers for the spectrum peak-hold block.
// Holds the log-magnitude word type, the peak-hold FSM state encoding and
// a saturating subtractor used by the decay path.
package spectrum_pkg;

  localparam int LOG_W = 8;

  typedef logic [LOG_W-1:0] log_t;

  typedef enum logic {
    PH_CLEAR = 1'b0,
    PH_RUN   = 1'b1
  } peak_state_t;

  // a - b, clamped at zero instead of wrapping
  function automatic log_t sat_sub(input log_t a, input log_t b);
    log_t res;
    if (a > b) begin
      res = a - b;
    end else begin
      res = {LOG_W{1'b0}};
    end
    return res;
  endfunction

endpackage

// File: rtl/spectrum_peak_hold_ram.sv
// peak_ram: simple dual-port RAM holding one peak value per FFT bin.
// One synchronous read port (1-cycle latency) and one write port, no reset,
// written so synthesis maps it onto block RAM.
module peak_ram
  import spectrum_pkg::*;
#(
  parameter int NUM_BINS = 512,
  parameter int ADDR_W   = $clog2(NUM_BINS)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] rd_addr,
  output log_t              rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  log_t              wr_data
);

  log_t mem_r [NUM_BINS];
  log_t rd_data_r;

  assign rd_data = rd_data_r;

  // write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // registered read port
  always_ff @(posedge clk) begin
    rd_data_r <= mem_r[rd_addr];
  end

endmodule

// File: rtl/spectrum_peak_hold.sv
// spectrum_peak_hold: per-bin peak hold over a framed log-magnitude stream.
// A CLEAR pass zeroes the peak RAM after reset or on request; in RUN each
// beat is merged with the held value (2-cycle latency) and streamed out.
// Optional decay: define SPECTRUM_PEAK_DECAY_EN to subtract DECAY_STEP from
// held values every DECAY_FRAMES frames; undefined gives pure max-hold.
module spectrum_peak_hold
  import spectrum_pkg::*;
#(
  parameter int          NUM_BINS     = 512,
  parameter int          DECAY_FRAMES = 4,
  parameter logic [7:0]  DECAY_STEP   = 8'd2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  log_in,
  input  logic                        log_valid,
  input  logic                        log_last,
  input  logic                        clear,
  output logic                        in_ready,
  output logic [7:0]                  peak_out,
  output logic [$clog2(NUM_BINS)-1:0] peak_bin,
  output logic                        peak_valid,
  output logic                        peak_last,
  output logic                        frame_done,
  output logic                        err_long,
  output logic                        err_short
);

  localparam int BIN_W = $clog2(NUM_BINS);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
  localparam logic [BIN_W-1:0] BIN_ZERO = {BIN_W{1'b0}};

  peak_state_t      state_r, state_nxt_s;
  logic [BIN_W-1:0] clr_addr_r, bin_cnt_r;
  logic             full_r;
  logic             accept_s, drop_s, first_s, decay_now_s;

  logic             s1_valid_r, s1_last_r, s1_decay_r;
  log_t             s1_log_r;
  logic [BIN_W-1:0] s1_bin_r;

  log_t             rd_data_s, held_s, new_val_s, wr_data_s;
  logic [BIN_W-1:0] wr_addr_s;
  logic             wr_en_s;

  log_t             peak_out_r;
  logic [BIN_W-1:0] peak_bin_r;
  logic             peak_valid_r, peak_last_r, frame_done_r;
  logic             in_ready_r, err_long_r, err_short_r;

  assign in_ready   = in_ready_r;
  assign peak_out   = peak_out_r;
  assign peak_bin   = peak_bin_r;
  assign peak_valid = peak_valid_r;
  assign peak_last  = peak_last_r;
  assign frame_done = frame_done_r;
  assign err_long   = err_long_r;
  assign err_short  = err_short_r;

  peak_ram #(.NUM_BINS(NUM_BINS), .ADDR_W(BIN_W)) u_ram (
    .clk     (clk),
    .rd_addr (bin_cnt_r),
    .rd_data (rd_data_s),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_data_s)
  );

  // next-state: CLEAR runs one full address sweep, a new request restarts it
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      PH_CLEAR: begin
        if (!clear && (clr_addr_r == LAST_BIN)) begin
          state_nxt_s = PH_RUN;
        end else begin
          state_nxt_s = PH_CLEAR;
        end
      end
      PH_RUN: begin
        if (clear) begin
          state_nxt_s = PH_CLEAR;
        end else begin
          state_nxt_s = PH_RUN;
        end
      end
      default: state_nxt_s = PH_CLEAR;
    endcase
  end

  // beat qualification: once bin NUM_BINS-1 is consumed, further beats are dropped
  always_comb begin
    accept_s = (state_r == PH_RUN) && log_valid;
    drop_s   = full_r;
    first_s  = (bin_cnt_r == BIN_ZERO) && !full_r;
  end

`ifdef SPECTRUM_PEAK_DECAY_EN
  localparam int FC_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(DECAY_FRAMES - 1);

  logic [FC_W-1:0] frame_cnt_r;
  logic            decay_flag_r;

  // decay decision is taken at the first beat and held for the whole frame
  always_comb begin
    if (first_s) begin
      decay_now_s = (frame_cnt_r == FC_LAST);
    end else begin
      decay_now_s = decay_flag_r;
    end
  end

  // frame counter (wraps every DECAY_FRAMES frames) and per-frame decay flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r  <= {FC_W{1'b0}};
      decay_flag_r <= 1'b0;
    end else if (state_r == PH_CLEAR) begin
      frame_cnt_r  <= {FC_W{1'b0}};
      decay_flag_r <= 1'b0;
    end else if (accept_s) begin
      if (first_s) begin
        decay_flag_r <= decay_now_s;
      end
      if (log_last) begin
        if (frame_cnt_r == FC_LAST) begin
          frame_cnt_r <= {FC_W{1'b0}};
        end else begin
          frame_cnt_r <= frame_cnt_r + 1'b1;
        end
      end
    end
  end
`else
  // max-hold only; DECAY_FRAMES is kept in the interface but has no effect
  always_comb begin
    decay_now_s = 1'b0 & (DECAY_FRAMES > 0);
  end
`endif

  // merge the held value (optionally decayed) with the incoming beat; CLEAR owns the write port
  always_comb begin
    held_s    = sat_sub(rd_data_s, s1_decay_r ? DECAY_STEP : 8'd0);
    new_val_s = (s1_log_r > held_s) ? s1_log_r : held_s;
    if (state_r == PH_CLEAR) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clr_addr_r;
      wr_data_s = {LOG_W{1'b0}};
    end else begin
      wr_en_s   = s1_valid_r;
      wr_addr_s = s1_bin_r;
      wr_data_s = new_val_s;
    end
  end

  // state register, clear sweep address and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= PH_CLEAR;
      clr_addr_r <= BIN_ZERO;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == PH_RUN);
      if ((state_r == PH_CLEAR) && !clear) begin
        clr_addr_r <= clr_addr_r + 1'b1;
      end else begin
        clr_addr_r <= BIN_ZERO;
      end
    end
  end

  // bin counter with saturation at the last bin for over-long frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt_r <= BIN_ZERO;
      full_r    <= 1'b0;
    end else if (state_r == PH_CLEAR) begin
      bin_cnt_r <= BIN_ZERO;
      full_r    <= 1'b0;
    end else if (accept_s) begin
      if (log_last) begin
        bin_cnt_r <= BIN_ZERO;
        full_r    <= 1'b0;
      end else if (bin_cnt_r == LAST_BIN) begin
        full_r    <= 1'b1;
      end else begin
        bin_cnt_r <= bin_cnt_r + 1'b1;
      end
    end
  end

  // sticky frame-length errors, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_long_r  <= 1'b0;
      err_short_r <= 1'b0;
    end else if (accept_s) begin
      if (drop_s) begin
        err_long_r <= 1'b1;
      end
      if (log_last && (bin_cnt_r != LAST_BIN)) begin
        err_short_r <= 1'b1;
      end
    end
  end

  // stage 1: capture beat context alongside the RAM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_decay_r <= 1'b0;
      s1_log_r   <= {LOG_W{1'b0}};
      s1_bin_r   <= BIN_ZERO;
    end else begin
      s1_valid_r <= accept_s && !drop_s;
      if (accept_s && !drop_s) begin
        s1_last_r  <= log_last;
        s1_decay_r <= decay_now_s;
        s1_log_r   <= log_in;
        s1_bin_r   <= bin_cnt_r;
      end
    end
  end

  // stage 2: registered output beat; in-flight beats still emit during CLEAR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_out_r   <= {LOG_W{1'b0}};
      peak_bin_r   <= BIN_ZERO;
      peak_valid_r <= 1'b0;
      peak_last_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      peak_valid_r <= s1_valid_r;
      peak_last_r  <= s1_valid_r && s1_last_r;
      frame_done_r <= s1_valid_r && s1_last_r;
      if (s1_valid_r) begin
        peak_out_r <= new_val_s;
        peak_bin_r <= s1_bin_r;
      end
    end
  end

endmodule

// File: tb/tb_spectrum_peak_hold.sv
// tb_spectrum_peak_hold: randomized and directed checks of spectrum_peak_hold
// against a frame-level reference model (per-bin array, beat index, frame count).
module tb_spectrum_peak_hold;

  localparam int         NB = 8;
  localparam int         DF = 2;
  localparam logic [7:0] DS = 8'd10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] log_in = 8'd0;
  logic       log_valid = 1'b0, log_last = 1'b0, clear = 1'b0;
  logic       in_ready, peak_valid, peak_last, frame_done, err_long, err_short;
  logic [7:0] peak_out;
  logic [2:0] peak_bin;

  spectrum_peak_hold #(.NUM_BINS(NB), .DECAY_FRAMES(DF), .DECAY_STEP(DS)) dut (
    .clk(clk), .rst_n(rst_n), .log_in(log_in), .log_valid(log_valid),
    .log_last(log_last), .clear(clear), .in_ready(in_ready),
    .peak_out(peak_out), .peak_bin(peak_bin), .peak_valid(peak_valid),
    .peak_last(peak_last), .frame_done(frame_done),
    .err_long(err_long), .err_short(err_short)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  val;
    logic [2:0]  bin;
    logic        last;
    logic        fd;
    logic [31:0] cyc;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       obs_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0, n_bad = 0;

  // reference model state
  logic [7:0] held[NB];
  int         m_k, m_fnum;
  logic       m_el, m_es;

  always @(posedge clk) cyc <= cyc + 1;

  // record every output beat together with the cycle it appeared in
  always @(negedge clk) begin
    beat_t b;
    if (peak_valid) begin
      b.val = peak_out; b.bin = peak_bin; b.last = peak_last; b.fd = frame_done; b.cyc = cyc;
      obs_q.push_back(b);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_clear();
    for (int i = 0; i < NB; i++) held[i] = 8'd0;
    m_k = 0;
    m_fnum = 0;
  endtask

  // drive one beat for one cycle and predict its output from the frame rules
  task automatic drive_beat(input logic [7:0] v, input logic l, input logic c);
    logic [7:0] d, h, nv;
    beat_t      b;
    log_in = v; log_valid = 1'b1; log_last = l; clear = c;
    if (in_ready) begin
      if (m_k < NB) begin
`ifdef SPECTRUM_PEAK_DECAY_EN
        d = ((m_fnum % DF) == DF - 1) ? DS : 8'd0;
`else
        d = 8'd0;
`endif
        h  = (held[m_k] > d) ? held[m_k] - d : 8'd0;
        nv = (v > h) ? v : h;
        held[m_k] = nv;
        b.val = nv; b.bin = 3'(m_k); b.last = l; b.fd = l; b.cyc = cyc + 2;
        exp_q.push_back(b);
      end else begin
        m_el = 1'b1;
      end
      if (l) begin
        if (m_k < NB - 1) m_es = 1'b1;
        m_k = 0;
        m_fnum++;
      end else begin
        m_k++;
      end
    end
    if (c) model_clear();
    @(posedge clk); #1;
    log_valid = 1'b0; log_last = 1'b0; clear = 1'b0;
  endtask

  task automatic drain();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic start_q();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, peak_valid, peak_last, frame_done, err_long, err_short, peak_out, peak_bin} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {in_ready, peak_valid, peak_last, frame_done, err_long, err_short, peak_out, peak_bin});
    end
    model_clear();
    m_el = 1'b0; m_es = 1'b0;
    start_q();
    rst_n = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (n !== 8) begin n_bad++; $display("FAIL reset_clear_len: got %0d cycles, expected 8", n); end
    for (int b = 0; b < NB; b++) drive_beat(8'd0, b == NB - 1, 1'b0);
    drain();
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL reset_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].val !== 8'd0) begin
        n_bad++; $display("FAIL reset_beat%0d: got %h, expected %h (val|bin|last|fd|cyc)", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ramp();
    start_q();
    for (int b = 0; b < NB; b++) drive_beat(8'(10 * b), b == NB - 1, 1'b0);
    drain();
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL ramp_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL ramp_beat%0d: got %h, expected %h (val|bin|last|fd|cyc)", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_decay();
    logic [7:0] want;
    start_q();
    for (int b = 0; b < NB; b++) drive_beat(8'h50, b == NB - 1, 1'b0);
    for (int b = 0; b < NB; b++) drive_beat(8'h00, b == NB - 1, 1'b0);
    drain();
`ifdef SPECTRUM_PEAK_DECAY_EN
    want = 8'h46;
`else
    want = 8'h50;
`endif
    n_cmp++;
    if (obs_q.size() !== 2 * NB) begin
      n_bad++; $display("FAIL decay_count: got %0d, expected %0d", obs_q.size(), 2 * NB);
    end else if (obs_q[2 * NB - 1].val !== want) begin
      n_bad++; $display("FAIL decay_value: got %h, expected %h", obs_q[2 * NB - 1].val, want);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL decay_beat%0d: got %h, expected %h (val|bin|last|fd|cyc)", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_saturate();
    int n;
    logic [7:0] want;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    n = 0;
    while (!in_ready && n < 50) begin n++; @(posedge clk); #1; end
    n_cmp++;
    if (n !== 8) begin n_bad++; $display("FAIL sat_clear_len: got %0d cycles, expected 8", n); end
    start_q();
    for (int b = 0; b < NB; b++) drive_beat(8'h05, b == NB - 1, 1'b0);
    for (int b = 0; b < NB; b++) drive_beat(8'h00, b == NB - 1, 1'b0);
    drain();
`ifdef SPECTRUM_PEAK_DECAY_EN
    want = 8'h00;
`else
    want = 8'h05;
`endif
    n_cmp++;
    if (obs_q.size() !== 2 * NB) begin
      n_bad++; $display("FAIL sat_count: got %0d, expected %0d", obs_q.size(), 2 * NB);
    end else if (obs_q[NB].val !== want) begin
      n_bad++; $display("FAIL sat_value: got %h, expected %h", obs_q[NB].val, want);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL sat_beat%0d: got %h, expected %h (val|bin|last|fd|cyc)", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_errors();
    n_cmp++;
    if ({err_long, err_short} !== 2'b00) begin n_bad++; $display("FAIL err_initial: got %b, expected 00", {err_long, err_short}); end
    start_q();
    for (int b = 0; b < 5; b++) drive_beat(8'($urandom), b == 4, 1'b0);
    drain();
    n_cmp++;
    if ({err_long, err_short} !== 2'b01) begin n_bad++; $display("FAIL err_short: got %b, expected 01", {err_long, err_short}); end
    for (int b = 0; b < NB; b++) drive_beat(8'($urandom), b == NB - 1, 1'b0);
    for (int b = 0; b < 10; b++) drive_beat(8'($urandom), b == 9, 1'b0);
    drain();
    n_cmp++;
    if ({err_long, err_short} !== {m_el, m_es}) begin
      n_bad++; $display("FAIL err_long: got %b, expected %b", {err_long, err_short}, {m_el, m_es});
    end
    n_cmp++;
    if (obs_q.size() !== 5 + NB + NB) begin n_bad++; $display("FAIL err_count: got %0d, expected %0d", obs_q.size(), 5 + 2 * NB); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL err_beat%0d: got %h, expected %h (val|bin|last|fd|cyc)", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_clear_midframe();
    int n;
    start_q();
    for (int b = 0; b < 4; b++) drive_beat(8'($urandom_range(16, 255)), 1'b0, b == 3);
    n = 0;
    while (!in_ready && n < 50) begin
      n++;
      drive_beat(8'($urandom), 1'b0, 1'b0);
    end
    n_cmp++;
    if (n !== 8) begin n_bad++; $display("FAIL clr_len: got %0d cycles, expected 8", n); end
    for (int b = 0; b < NB; b++) drive_beat(8'h01, b == NB - 1, 1'b0);
    drain();
    n_cmp++;
    if (obs_q.size() !== 4 + NB) begin n_bad++; $display("FAIL clr_count: got %0d, expected %0d", obs_q.size(), 4 + NB); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL clr_beat%0d: got %h, expected %h (val|bin|last|fd|cyc)", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if ({err_long, err_short} !== {m_el, m_es}) begin
      n_bad++; $display("FAIL clr_sticky: got %b, expected %b", {err_long, err_short}, {m_el, m_es});
    end
  endtask

  task automatic test_random();
    int len;
    start_q();
    for (int f = 0; f < 10; f++) begin
      len = $urandom_range(3, 11);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          log_valid = 1'b0;
          @(posedge clk); #1;
        end
        drive_beat(8'($urandom), b == len - 1, $urandom_range(0, 30) == 0);
      end
    end
    drain();
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL rand_beat%0d: got %h, expected %h (val|bin|last|fd|cyc)", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if ({err_long, err_short} !== {m_el, m_es}) begin
      n_bad++; $display("FAIL rand_errs: got %b, expected %b", {err_long, err_short}, {m_el, m_es});
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_decay();
    test_saturate();
    test_errors();
    test_clear_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
